// File: rtl/ram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ram_ctrl_pkg
// Shared definitions for the single-port RAM controller:
//   - state_t       : controller states (CLEAR runs the init sweep, SERVE
//                     arbitrates client traffic)
//   - DEF_DATA_W    : default RAM word width
//   - DEF_ADDR_W    : default RAM address width
//   - DEF_CLEAR_VAL : default value written to every location after reset
// ---------------------------------------------------------------------------
package ram_ctrl_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam int         DEF_DATA_W    = 8;
    localparam int         DEF_ADDR_W    = 4;
    localparam logic [7:0] DEF_CLEAR_VAL = 8'h00;

endpackage

// File: rtl/ram_sp_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter with a one-hot, combinational grant.
//   clk, rst : clock and synchronous active-high reset
//   req      : request vector, bit n = requester n
//   advance  : strobe; the current grant completed a handshake
//   gnt      : one-hot grant (all zeros when nothing is requested)
// The priority pointer moves only on advance, so a requester that is stalled
// keeps its turn until it is actually served.
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 0: requester 0 wins a tie, 1: requester 1 wins a tie
    logic ptr;

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves it unassigned, which would infer a latch.
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop
        // samples its inputs from before the edge.
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance) begin
            // Tie priority passes to whichever requester was not just served.
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/ram_sp_arbiter.sv
// ---------------------------------------------------------------------------
// ram_sp_arbiter
// Controller that owns the single port of a 2^ADDR_W x DATA_W RAM
// (synchronous write, asynchronous read). After reset it clears every
// location to CLEAR_VAL, then shares the port between two requesters with
// round-robin arbitration and valid/ready handshakes.
//   clk, rst               : clock, synchronous active-high reset
//   req_valid_n/ready_n    : request handshake, n = 0,1
//   req_we_n               : 1 = write, 0 = read
//   req_addr_n/req_wdata_n : request address and write data
//   rsp_valid_n/rsp_rdata_n: read response, valid for exactly one cycle
//   mem_addr/wdata/we      : RAM port driven by this block
//   mem_rdata              : RAM asynchronous read data
//   init_done              : clear sweep finished, high until next reset
// ---------------------------------------------------------------------------
module ram_sp_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] CLEAR_VAL = DATA_W'(DEF_CLEAR_VAL)
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_valid_0,
    output logic              req_ready_0,
    input  logic              req_we_0,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [DATA_W-1:0] req_wdata_0,
    output logic              rsp_valid_0,
    output logic [DATA_W-1:0] rsp_rdata_0,

    input  logic              req_valid_1,
    output logic              req_ready_1,
    input  logic              req_we_1,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [DATA_W-1:0] req_wdata_1,
    output logic              rsp_valid_1,
    output logic [DATA_W-1:0] rsp_rdata_1,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              init_done
);

    localparam int DEPTH = 1 << ADDR_W;

    state_t            state;
    // One bit wider than the address so the sweep end is unambiguous.
    logic [ADDR_W:0]   clr_cnt;

    logic              serve;
    logic [1:0]        req_vec;
    logic [1:0]        gnt;
    logic              hs_0;
    logic              hs_1;

    // Requests are only visible to the arbiter while serving and not in
    // reset, so ready and the pointer are both held off during those times.
    assign serve   = (state == SERVE) && !rst;
    assign req_vec = serve ? {req_valid_1, req_valid_0} : 2'b00;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_vec),
        .advance (hs_0 | hs_1),
        .gnt     (gnt)
    );

    // A grant is only issued to a valid requester, so ready alone marks the
    // handshake.
    assign req_ready_0 = gnt[0];
    assign req_ready_1 = gnt[1];
    assign hs_0        = req_valid_0 & req_ready_0;
    assign hs_1        = req_valid_1 & req_ready_1;

    // RAM port mux: clear sweep, granted request, or idle zeros.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            if (state == CLEAR) begin
                mem_we    = 1'b1;
                mem_addr  = clr_cnt[ADDR_W-1:0];
                mem_wdata = CLEAR_VAL;
            end else if (gnt[0]) begin
                mem_we    = req_we_0;
                mem_addr  = req_addr_0;
                mem_wdata = req_wdata_0;
            end else if (gnt[1]) begin
                mem_we    = req_we_1;
                mem_addr  = req_addr_1;
                mem_wdata = req_wdata_1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= CLEAR;
            clr_cnt     <= '0;
            init_done   <= 1'b0;
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
            rsp_rdata_0 <= '0;
            rsp_rdata_1 <= '0;
        end else begin
            // Read data is captured from the asynchronous RAM output in the
            // accept cycle; the other requester's data register holds.
            rsp_valid_0 <= hs_0 & ~req_we_0;
            rsp_valid_1 <= hs_1 & ~req_we_1;
            if (hs_0 && !req_we_0) begin
                rsp_rdata_0 <= mem_rdata;
            end
            if (hs_1 && !req_we_1) begin
                rsp_rdata_1 <= mem_rdata;
            end

            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == (ADDR_W+1)'(DEPTH - 1)) begin
                        state     <= SERVE;
                        init_done <= 1'b1;
                    end
                end
                SERVE: begin
                    state <= SERVE;
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_sp_arbiter
// Bench for ram_sp_arbiter. A behavioural RAM sits beside the DUT. A
// reference model (memory image, last-granted requester, pending responses)
// is checked against the DUT on every falling edge; directed sequences add
// literal expectations for the clear sweep, read-after-write, alternation,
// simultaneous access and mid-operation reset.
// ---------------------------------------------------------------------------
module tb_ram_sp_arbiter;

    localparam int         DW   = 8;
    localparam int         AW   = 4;
    localparam int         DEP  = 16;
    localparam logic [7:0] CVAL = 8'h00;

    logic          clk;
    logic          rst;
    logic          req_valid_0, req_ready_0, req_we_0, rsp_valid_0;
    logic [AW-1:0] req_addr_0;
    logic [DW-1:0] req_wdata_0, rsp_rdata_0;
    logic          req_valid_1, req_ready_1, req_we_1, rsp_valid_1;
    logic [AW-1:0] req_addr_1;
    logic [DW-1:0] req_wdata_1, rsp_rdata_1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_we;
    logic          init_done;

    int n_checks = 0;
    int n_errors = 0;

    ram_sp_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_VAL(CVAL)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_0 (req_valid_0),
        .req_ready_0 (req_ready_0),
        .req_we_0    (req_we_0),
        .req_addr_0  (req_addr_0),
        .req_wdata_0 (req_wdata_0),
        .rsp_valid_0 (rsp_valid_0),
        .rsp_rdata_0 (rsp_rdata_0),
        .req_valid_1 (req_valid_1),
        .req_ready_1 (req_ready_1),
        .req_we_1    (req_we_1),
        .req_addr_1  (req_addr_1),
        .req_wdata_1 (req_wdata_1),
        .rsp_valid_1 (rsp_valid_1),
        .rsp_rdata_1 (rsp_rdata_1),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata),
        .init_done   (init_done)
    );

    // Behavioural single-port RAM: synchronous write, asynchronous read.
    logic [DW-1:0] ram [DEP];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = ram[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model, advanced once per cycle at the falling edge using
    // the inputs that will be sampled at the next rising edge.
    // ------------------------------------------------------------------
    logic [7:0] m_mem [DEP];
    bit         m_clearing = 1'b1;
    int         m_idx      = 0;
    bit         m_init     = 1'b0;
    int         m_last     = 1;
    bit         m_rv [2]   = '{1'b0, 1'b0};
    logic [7:0] m_rd [2]   = '{8'h00, 8'h00};

    initial begin
        int         g;
        logic       v0, v1, gwe;
        logic [3:0] gaddr;
        logic [7:0] gwd;
        @(posedge clk);
        forever begin
            @(negedge clk);
            v0 = req_valid_0;
            v1 = req_valid_1;
            g  = -1;

            // Registered outputs reflect the model state after the last edge.
            check("rsp_valid_0", 32'(rsp_valid_0), 32'(m_rv[0]));
            check("rsp_valid_1", 32'(rsp_valid_1), 32'(m_rv[1]));
            check("rsp_rdata_0", 32'(rsp_rdata_0), 32'(m_rd[0]));
            check("rsp_rdata_1", 32'(rsp_rdata_1), 32'(m_rd[1]));
            check("init_done",   32'(init_done),   32'(m_init));

            if (rst) begin
                check("rst_we",      32'(mem_we),      32'd0);
                check("rst_ready_0", 32'(req_ready_0), 32'd0);
                check("rst_ready_1", 32'(req_ready_1), 32'd0);
            end else if (m_clearing) begin
                check("clr_we",      32'(mem_we),      32'd1);
                check("clr_addr",    32'(mem_addr),    32'(m_idx));
                check("clr_wdata",   32'(mem_wdata),   32'(CVAL));
                check("clr_ready_0", 32'(req_ready_0), 32'd0);
                check("clr_ready_1", 32'(req_ready_1), 32'd0);
            end else begin
                if (v0 && v1) g = (m_last == 0) ? 1 : 0;
                else if (v0)  g = 0;
                else if (v1)  g = 1;
                check("ready_0", 32'(req_ready_0), 32'(g == 0));
                check("ready_1", 32'(req_ready_1), 32'(g == 1));
                if (g < 0) begin
                    check("idle_we",    32'(mem_we),    32'd0);
                    check("idle_addr",  32'(mem_addr),  32'd0);
                    check("idle_wdata", 32'(mem_wdata), 32'd0);
                end else begin
                    gwe   = (g == 0) ? req_we_0    : req_we_1;
                    gaddr = (g == 0) ? req_addr_0  : req_addr_1;
                    gwd   = (g == 0) ? req_wdata_0 : req_wdata_1;
                    check("grant_we",   32'(mem_we),   32'(gwe));
                    check("grant_addr", 32'(mem_addr), 32'(gaddr));
                    if (gwe) check("grant_wdata", 32'(mem_wdata), 32'(gwd));
                end
            end

            // Advance model to the state after the coming rising edge.
            if (rst) begin
                m_clearing = 1'b1;
                m_idx      = 0;
                m_init     = 1'b0;
                m_last     = 1;
                m_rv       = '{1'b0, 1'b0};
                m_rd       = '{8'h00, 8'h00};
            end else begin
                m_rv = '{1'b0, 1'b0};
                if (m_clearing) begin
                    m_mem[m_idx] = CVAL;
                    if (m_idx == DEP - 1) begin
                        m_clearing = 1'b0;
                        m_init     = 1'b1;
                    end
                    m_idx++;
                end else if (g >= 0) begin
                    if (gwe) begin
                        m_mem[gaddr] = gwd;
                    end else begin
                        m_rv[g] = 1'b1;
                        m_rd[g] = m_mem[gaddr];
                    end
                    m_last = g;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus. Inputs change only 1 time unit after a rising edge.
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic v, input logic we,
                           input logic [3:0] a, input logic [7:0] d);
        if (n == 0) begin
            req_valid_0 = v; req_we_0 = we; req_addr_0 = a; req_wdata_0 = d;
        end else begin
            req_valid_1 = v; req_we_1 = we; req_addr_1 = a; req_wdata_1 = d;
        end
    endtask

    // Present a request, hold it until accepted (bounded), then drop it.
    // Returns one time unit after the accepting edge.
    task automatic access(input int n, input logic we, input logic [3:0] a, input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        set_req(n, 1'b1, we, a, d);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((n == 0) ? req_ready_0 : req_ready_1) begin
                ok = 1'b1;
                break;
            end
        end
        check("access_accepted", 32'(ok), 32'd1);
        step();
        set_req(n, 1'b0, 1'b0, 4'd0, 8'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, 4'd0, 8'd0);
        set_req(1, 1'b0, 1'b0, 4'd0, 8'd0);
        repeat (2) step();
        rst = 1'b0;

        // Clear sweep: init_done rises at cycle 16 after release.
        cyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("c0_we",    32'(mem_we),    32'd1);
                check("c0_addr",  32'(mem_addr),  32'd0);
                check("c0_wdata", 32'(mem_wdata), 32'h00);
                check("c0_init",  32'(init_done), 32'd0);
            end
            if (init_done) begin
                cyc = i;
                break;
            end
        end
        check("init_cycle", 32'(cyc), 32'd16);
        step();

        // Every location reads back the clear value (via requester 1).
        for (int a = 0; a < DEP; a++) begin
            access(1, 1'b0, 4'(a), 8'h00);
            @(negedge clk);
            check("clr_rd_valid", 32'(rsp_valid_1), 32'd1);
            check("clr_rd_data",  32'(rsp_rdata_1), 32'h00);
            step();
        end

        // Simultaneous write (req0) and read (req1) to address 7.
        set_req(0, 1'b1, 1'b1, 4'd7, 8'h3C);
        set_req(1, 1'b1, 1'b0, 4'd7, 8'h00);
        @(negedge clk);
        check("sim_first_0", 32'(req_ready_0), 32'd1);
        check("sim_first_1", 32'(req_ready_1), 32'd0);
        step();
        set_req(0, 1'b0, 1'b0, 4'd0, 8'd0);
        @(negedge clk);
        check("sim_second_1", 32'(req_ready_1), 32'd1);
        step();
        set_req(1, 1'b0, 1'b0, 4'd0, 8'd0);
        @(negedge clk);
        check("sim_rsp_valid_1", 32'(rsp_valid_1), 32'd1);
        check("sim_rsp_data_1",  32'(rsp_rdata_1), 32'h3C);
        check("sim_rsp_valid_0", 32'(rsp_valid_0), 32'd0);
        step();

        // Write then read the same address on consecutive cycles.
        access(0, 1'b1, 4'd4, 8'hA5);
        access(0, 1'b0, 4'd4, 8'h00);
        @(negedge clk);
        check("raw_valid_0", 32'(rsp_valid_0), 32'd1);
        check("raw_data_0",  32'(rsp_rdata_0), 32'hA5);
        check("raw_valid_1", 32'(rsp_valid_1), 32'd0);
        step();

        // Both requesters reading continuously: grants alternate 0,1,...
        access(0, 1'b1, 4'd1, 8'h11);
        access(1, 1'b1, 4'd2, 8'h22);
        set_req(0, 1'b1, 1'b0, 4'd1, 8'h00);
        set_req(1, 1'b1, 1'b0, 4'd2, 8'h00);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rr_grant_1", 32'(req_ready_1), 32'(i % 2));
            check("rr_onehot",  32'(req_ready_0 ^ req_ready_1), 32'd1);
            if (i > 0) begin
                if ((i % 2) == 1) begin
                    check("rr_rsp_v0", 32'(rsp_valid_0), 32'd1);
                    check("rr_rsp_d0", 32'(rsp_rdata_0), 32'h11);
                    check("rr_rsp_q1", 32'(rsp_valid_1), 32'd0);
                end else begin
                    check("rr_rsp_v1", 32'(rsp_valid_1), 32'd1);
                    check("rr_rsp_d1", 32'(rsp_rdata_1), 32'h22);
                    check("rr_rsp_q0", 32'(rsp_valid_0), 32'd0);
                end
            end
        end
        step();
        set_req(0, 1'b0, 1'b0, 4'd0, 8'd0);
        set_req(1, 1'b0, 1'b0, 4'd0, 8'd0);
        @(negedge clk);
        check("rr_last_v1", 32'(rsp_valid_1), 32'd1);
        check("rr_last_d1", 32'(rsp_rdata_1), 32'h22);
        step();

        // Reset pulsed while a read response is outstanding; a request held
        // through the restarted clear is accepted at cycle 16.
        access(0, 1'b1, 4'd9, 8'h5A);
        access(0, 1'b0, 4'd9, 8'h00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 4'd9, 8'h00);
        cyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("rr0_rsp_valid", 32'(rsp_valid_0), 32'd0);
                check("rr0_init",      32'(init_done),   32'd0);
                check("rr0_addr",      32'(mem_addr),    32'd0);
                check("rr0_we",        32'(mem_we),      32'd1);
            end
            if (req_ready_0) begin
                cyc = i;
                break;
            end
        end
        check("ready_cycle", 32'(cyc), 32'd16);
        check("ready_init",  32'(init_done), 32'd1);
        step();
        set_req(0, 1'b0, 1'b0, 4'd0, 8'd0);
        @(negedge clk);
        check("post_rst_valid", 32'(rsp_valid_0), 32'd1);
        check("post_rst_data",  32'(rsp_rdata_0), 32'h00);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
